// File: rtl/vga_timing_gen.sv
// Raster timing generator with built-in test patterns for the video path.
// All outputs except video_clk are registered and lag the hc/vc counters by one cycle.
module vga_timing_gen #(
  parameter int HDISP     = 800,
  parameter int VDISP     = 480,
  parameter int HFP       = 40,
  parameter int HPULSE    = 48,
  parameter int HBP       = 40,
  parameter int VFP       = 13,
  parameter int VPULSE    = 3,
  parameter int VBP       = 29,
  parameter int HS_POL    = 0,
  parameter int VS_POL    = 0,
  parameter int CW        = 8,
  parameter int GRID_LOG2 = 4,
  parameter int GSHIFT    = 2,
  localparam int HTOTAL   = HDISP + HFP + HPULSE + HBP,
  localparam int VTOTAL   = VDISP + VFP + VPULSE + VBP,
  localparam int XW       = $clog2(HTOTAL),
  localparam int YW       = $clog2(VTOTAL)
) (
  input  logic            pixel_clk,
  input  logic            pixel_rst,
  input  logic [1:0]      mode_i,
  output logic            video_clk,
  output logic            hs,
  output logic            vs,
  output logic            de,
  output logic            blank_n,
  output logic [XW-1:0]   x,
  output logic [YW-1:0]   y,
  output logic [3*CW-1:0] rgb,
  output logic            sof,
  output logic            eol
);

  typedef enum logic [1:0] {PAT_GRID, PAT_BARS, PAT_GRAD, PAT_CHECK} pattern_e;

  localparam logic [XW-1:0] H_ACT_END  = XW'(HDISP);
  localparam logic [XW-1:0] H_ACT_LAST = XW'(HDISP - 1);
  localparam logic [XW-1:0] H_SYNC_BEG = XW'(HDISP + HFP);
  localparam logic [XW-1:0] H_SYNC_END = XW'(HDISP + HFP + HPULSE);
  localparam logic [XW-1:0] H_LAST     = XW'(HTOTAL - 1);
  localparam logic [YW-1:0] V_ACT_END  = YW'(VDISP);
  localparam logic [YW-1:0] V_SYNC_BEG = YW'(VDISP + VFP);
  localparam logic [YW-1:0] V_SYNC_END = YW'(VDISP + VFP + VPULSE);
  localparam logic [YW-1:0] V_LAST     = YW'(VTOTAL - 1);
  localparam logic          HS_ON      = 1'(HS_POL);
  localparam logic          VS_ON      = 1'(VS_POL);
  localparam logic [CW-1:0] WHITE      = '1;

  if (HFP < 1 || HPULSE < 1 || HBP < 1 || VFP < 1 || VPULSE < 1 || VBP < 1 ||
      (HDISP % 8) != 0) begin : g_param_check
    $error("vga_timing_gen: porch/sync widths must be >= 1 and HDISP a multiple of 8");
  end

  logic [XW-1:0]   hc;
  logic [YW-1:0]   vc;
  pattern_e        mode_q;
  logic            line_end;
  logic            frame_end;
  logic            h_act;
  logic            v_act;
  logic            act;
  logic            hs_d;
  logic            vs_d;
  logic [2:0]      bar;
  logic [2:0]      bar_mask;
  logic [CW-1:0]   grad;
  logic [3*CW-1:0] rgb_d;

  assign video_clk = pixel_clk;
  assign line_end  = (hc == H_LAST);
  assign frame_end = (vc == V_LAST);

  // NOTE: state uses non-blocking assignments and the async reset sits in the sensitivity list,
  // so every register clears the moment pixel_rst rises, not at the next edge.
  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      hc     <= '0;
      vc     <= '0;
      mode_q <= PAT_GRID;
    end else begin
      if (line_end) begin
        hc <= '0;
        vc <= frame_end ? '0 : vc + YW'(1);
      end else begin
        hc <= hc + XW'(1);
      end
      // Pattern switches only on the last counter state of a frame, so frames never tear.
      if (line_end && frame_end) mode_q <= pattern_e'(mode_i);
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    h_act = (hc < H_ACT_END);
    v_act = (vc < V_ACT_END);
    act   = h_act && v_act;
    hs_d  = (hc >= H_SYNC_BEG && hc < H_SYNC_END) ? HS_ON : ~HS_ON;
    vs_d  = (vc >= V_SYNC_BEG && vc < V_SYNC_END) ? VS_ON : ~VS_ON;
  end

  always_comb begin
    bar = '0;
    for (int k = 1; k < 8; k++) begin
      if (hc >= XW'(k * HDISP / 8)) bar = 3'(k);
    end
    // {R,G,B} enables: white, yellow, cyan, green, magenta, red, blue, black.
    unique case (bar)
      3'd0:    bar_mask = 3'b111;
      3'd1:    bar_mask = 3'b110;
      3'd2:    bar_mask = 3'b011;
      3'd3:    bar_mask = 3'b010;
      3'd4:    bar_mask = 3'b101;
      3'd5:    bar_mask = 3'b100;
      3'd6:    bar_mask = 3'b001;
      default: bar_mask = 3'b000;
    endcase
  end

  always_comb begin
    grad  = CW'(hc >> GSHIFT);
    rgb_d = '0;
    unique case (mode_q)
      PAT_GRID: begin
        if (hc[GRID_LOG2-1:0] == '0 || vc[GRID_LOG2-1:0] == '0) rgb_d = {3{WHITE}};
      end
      PAT_BARS: begin
        rgb_d = {{CW{bar_mask[2]}}, {CW{bar_mask[1]}}, {CW{bar_mask[0]}}};
      end
      PAT_GRAD: begin
        rgb_d = {3{grad}};
      end
      PAT_CHECK: begin
        if (hc[GRID_LOG2] ^ vc[GRID_LOG2]) rgb_d = {3{WHITE}};
      end
    endcase
  end

  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      hs      <= ~HS_ON;
      vs      <= ~VS_ON;
      de      <= 1'b0;
      blank_n <= 1'b0;
      x       <= '0;
      y       <= '0;
      rgb     <= '0;
      sof     <= 1'b0;
      eol     <= 1'b0;
    end else begin
      hs      <= hs_d;
      vs      <= vs_d;
      de      <= act;
      blank_n <= act;
      x       <= act ? hc : '0;
      y       <= act ? vc : '0;
      rgb     <= act ? rgb_d : '0;
      sof     <= act && (hc == '0) && (vc == '0);
      eol     <= v_act && (hc == H_ACT_LAST);
    end
  end

endmodule
